// File: rtl/bht_update_buffer.sv
// bht_update_buffer
//
// Queues BHT training updates for resolved conditional branches and drains
// them to the BHT through a valid/ready handshake. JUMPs are filtered out.
// Saturating statistics count conditional branches, mispredicts and updates
// dropped because the queue was full.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 discard every queued update
//   resolve_*_i             resolved control-flow outcome from execute
//   bht_update_valid_o      head entry available (first-word fall-through)
//   bht_update_pc_o/taken_o head entry contents
//   bht_update_ready_i      BHT accepts the head entry
//   level_o                 current queue occupancy
//   cond_count_o            resolved conditional branches (saturating)
//   mispredict_count_o      mispredicted conditional branches (saturating)
//   drop_count_o            updates lost to a full queue (saturating)
module bht_update_buffer #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     resolve_valid_i,
  input  logic [VLEN-1:0]          resolve_pc_i,
  input  logic                     resolve_is_cond_i,
  input  logic                     resolve_taken_i,
  input  logic                     resolve_mispredict_i,
  output logic                     bht_update_valid_o,
  output logic [VLEN-1:0]          bht_update_pc_o,
  output logic                     bht_update_taken_o,
  input  logic                     bht_update_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         cond_count_o,
  output logic [CNT_W-1:0]         mispredict_count_o,
  output logic [CNT_W-1:0]         drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int NCNT  = 3;

  // Entry storage; never reset, contents are only observed while level != 0.
  logic [VLEN-1:0]  pc_mem    [DEPTH];
  logic             taken_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;

  logic             cand;
  logic             deq;
  logic             full;
  logic             enq;
  logic             drop;
  logic [NCNT-1:0]  cnt_inc;

  always_comb begin
    cand = resolve_valid_i & resolve_is_cond_i;
    full = (level_reg == LVL_W'(DEPTH));
    // A flush wins over any handshake in the same cycle.
    deq  = (level_reg != '0) & bht_update_ready_i & ~flush_i;
    // A full queue still accepts when the head leaves in the same cycle.
    enq  = cand & ~flush_i & (~full | deq);
    // Candidates discarded by a flush are not drops.
    drop = cand & ~flush_i & full & ~deq;

    level_next = level_reg + LVL_W'(enq) - LVL_W'(deq);

    // Statistics count every candidate whether or not it was queued.
    cnt_inc[0] = cand;
    cnt_inc[1] = cand & resolve_mispredict_i;
    cnt_inc[2] = drop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wr_ptr_reg]    <= resolve_pc_i;
      taken_mem[wr_ptr_reg] <= resolve_taken_i;
    end
  end

  // Outputs come only from registered state: no resolve_* input reaches them
  // combinationally, so a candidate is never bypassed to the output.
  assign bht_update_valid_o = (level_reg != '0);
  assign bht_update_pc_o    = pc_mem[rd_ptr_reg];
  assign bht_update_taken_o = taken_mem[rd_ptr_reg];
  assign level_o            = level_reg;

  // Saturating statistics counters: 0 = cond, 1 = mispredict, 2 = drop.
  genvar gi;
  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cond_count_o       = g_cnt[0].cnt_reg;
  assign mispredict_count_o = g_cnt[1].cnt_reg;
  assign drop_count_o       = g_cnt[2].cnt_reg;

endmodule

// File: doc/bht_update_buffer.md
Name: bht_update_buffer

Overview:
- Receives resolved control-flow outcomes from the execute stage and queues BHT training updates for conditional branches only.
- Drains the queue to the BHT update port through a valid/ready handshake.
- Keeps saturating statistics: conditional branches, mispredicts and dropped updates.
- Sits between the branch unit and the BHT. It is the hardware consumer of the branch streams (JUMP / CONDITIONAL) the BHT bench generates.

Parameters:
- VLEN, 64, PC width in bits.
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard all queued updates (frontend flush).
- resolve_valid_i  in  1  a control-flow instruction resolved this cycle.
- resolve_pc_i  in  VLEN  PC of the resolved instruction.
- resolve_is_cond_i  in  1  1 = CONDITIONAL, 0 = JUMP.
- resolve_taken_i  in  1  actual direction.
- resolve_mispredict_i  in  1  predicted direction differed from actual.
- bht_update_valid_o  out  1  head entry is available.
- bht_update_pc_o  out  VLEN  head entry PC.
- bht_update_taken_o  out  1  head entry direction.
- bht_update_ready_i  in  1  BHT accepts the head entry.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- cond_count_o  out  CNT_W  resolved conditional branches.
- mispredict_count_o  out  CNT_W  mispredicted conditional branches.
- drop_count_o  out  CNT_W  updates lost to a full queue.

Behaviour:
- Reset: asynchronous on rst_i high. Pointers, level and all counters go to 0. bht_update_valid_o = 0. Entry storage need not be reset; pc/taken outputs are don't-care while valid is 0.
- Storage: circular buffer with read pointer, write pointer and level counter. Pointers wrap modulo DEPTH.
- Output is first-word fall-through from registered storage:
  - bht_update_valid_o = (level != 0).
  - pc/taken come from the head entry.
  - No combinational path from any resolve_* input to any bht_update_* output.
- Enqueue candidate: resolve_valid_i && resolve_is_cond_i. JUMPs are never queued and never counted.
- Dequeue: bht_update_valid_o && bht_update_ready_i; read pointer advances at the clock edge.
- Latency: a candidate accepted at edge N is visible on the outputs in the cycle after edge N (1 cycle), provided the queue was empty.
- Full queue (level == DEPTH):
  - Candidate with a dequeue in the same cycle: accepted, level unchanged.
  - Candidate with no dequeue: discarded, drop_count_o += 1.
- Empty queue: ready is ignored and no dequeue occurs. A candidate on an empty queue is never bypassed to the output in the same cycle.
- Handshake: once valid is high, head pc/taken stay stable until dequeued or flushed. Valid never drops without a dequeue or flush.
- Flush (flush_i high at an edge):
  - Read pointer, write pointer and level go to 0; any dequeue that cycle is ignored.
  - A candidate in the same cycle is discarded and is not counted as a drop.
  - cond_count_o and mispredict_count_o still count that candidate.
- Statistics, per candidate regardless of acceptance:
  - cond_count_o += 1.
  - mispredict_count_o += 1 if resolve_mispredict_i.
  - resolve_mispredict_i on a JUMP is ignored.
- All counters saturate at 2^CNT_W-1; no wrap.
- Precedence: rst_i > flush_i > enqueue/dequeue.
- Reset mid-operation clears all state immediately (asynchronous). Outputs are valid = 0 from the reset assertion onward; no partial entry survives.

Test Plan:
- Three conditional resolves at PC 0x1000/0x1004/0x1008 (taken 1/0/1), ready=1 -> outputs appear in the same order one cycle after each. level_o peaks at 1; cond_count_o = 3.
- Two JUMP resolves with mispredict=1, then one conditional with mispredict=1 -> only the conditional is queued; cond_count_o = 1, mispredict_count_o = 1.
- ready=0 with 6 conditional resolves, DEPTH=4 -> level_o = 4, drop_count_o = 2. Head stays at the first PC. Raising ready drains the 4 entries in order.
- Full queue, ready=1 plus a new conditional in the same cycle -> it is accepted, level_o stays 4, drop_count_o unchanged, and the new entry exits last.
- Level 3 with flush_i and a conditional resolve in the same cycle -> level_o = 0 and valid = 0 next cycle. cond_count_o increments; drop_count_o does not.
- CNT_W=4 with 20 conditional mispredicts, ready=1 -> cond_count_o and mispredict_count_o hold at 15. Asserting rst_i mid-stream zeroes them and level_o without waiting for a clock edge.
